// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU register-file arbiter.
// Defines the datapath widths, FSM state encoding and requester identifiers.
package cpu_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/cpu_reg_arbiter_if.sv
// Bundle of requester handshakes (cpu_*, dbg_*) and register-file strobes.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface cpu_reg_arbiter_if;
    import cpu_pkg::*;

    logic                 cpu_req;
    logic                 cpu_we;
    logic [REG_SEL_W-1:0] cpu_addr;
    logic [DATA_W-1:0]    cpu_wdata;
    logic                 cpu_ack;
    logic [DATA_W-1:0]    cpu_rdata;
    logic                 cpu_err;

    logic                 dbg_req;
    logic                 dbg_we;
    logic [REG_SEL_W-1:0] dbg_addr;
    logic [DATA_W-1:0]    dbg_wdata;
    logic                 dbg_ack;
    logic [DATA_W-1:0]    dbg_rdata;
    logic                 dbg_err;

    logic [DATA_W-1:0]    rf_data_in;
    logic [REG_SEL_W-1:0] rf_sel_in;
    logic [REG_SEL_W-1:0] rf_sel_out;
    logic                 rf_enable_write;
    logic                 rf_output_enable;
    logic [DATA_W-1:0]    rf_data_out;

    logic                 busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  rf_data_out,
        output cpu_ack, cpu_rdata, cpu_err,
        output dbg_ack, dbg_rdata, dbg_err,
        output rf_data_in, rf_sel_in, rf_sel_out, rf_enable_write, rf_output_enable,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output rf_data_out,
        input  cpu_ack, cpu_rdata, cpu_err,
        input  dbg_ack, dbg_rdata, dbg_err,
        input  rf_data_in, rf_sel_in, rf_sel_out, rf_enable_write, rf_output_enable,
        input  busy
    );

endinterface

// File: rtl/cpu_reg_arb_pick.sv
// Winner selection for the register-file arbiter: CPU has fixed priority unless
// the debug requester has lost MAX_WAIT consecutive arbitrations.
module cpu_reg_arb_pick
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_arb_en,
    input  logic i_cpu_req,
    input  logic i_dbg_req,
    output logic o_grant_vld,
    output logic o_grant_id
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_dbg_forced;

    assign w_dbg_forced = i_dbg_req && (r_wait_cnt == CNT_MAX);
    assign o_grant_vld  = i_cpu_req || i_dbg_req;

    always_comb begin
        o_grant_id = REQ_DBG;
        if (w_dbg_forced) begin
            o_grant_id = REQ_DBG;
        end else if (i_cpu_req) begin
            o_grant_id = REQ_CPU;
        end
    end

    // Counts only arbitrations debug actually lost; saturates at the force threshold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (i_arb_en && o_grant_vld) begin
            if (o_grant_id == REQ_DBG) begin
                r_wait_cnt <= '0;
            end else if (i_dbg_req && (r_wait_cnt != CNT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_reg_arbiter.sv
// Arbitrates CPU and debug access to the register file and sequences rf strobes.
// Optional address range check enabled by defining CPU_REG_ARB_ADDR_CHECK_EN.
module cpu_reg_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    cpu_reg_arbiter_if.slave  bus
);

    if (NUM_REGS < 1 || NUM_REGS > (1 << REG_SEL_W)) begin : g_bad_num_regs
        $error("cpu_reg_arbiter: NUM_REGS out of range for the register select width");
    end

    state_t               r_state;
    state_t               w_next;
    logic                 r_id;
    logic [REG_SEL_W-1:0] r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_cpu_rdata;
    logic [DATA_W-1:0]    r_dbg_rdata;

    logic                 w_idle;
    logic                 w_grant_vld;
    logic                 w_grant_id;
    logic                 w_sel_we;
    logic [REG_SEL_W-1:0] w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_addr_ok;
    logic                 w_resp_err;

    assign w_idle = (r_state == IDLE);

    cpu_reg_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_arb_en    (w_idle),
        .i_cpu_req   (bus.cpu_req),
        .i_dbg_req   (bus.dbg_req),
        .o_grant_vld (w_grant_vld),
        .o_grant_id  (w_grant_id)
    );

    assign w_sel_we    = (w_grant_id == REQ_DBG) ? bus.dbg_we    : bus.cpu_we;
    assign w_sel_addr  = (w_grant_id == REQ_DBG) ? bus.dbg_addr  : bus.cpu_addr;
    assign w_sel_wdata = (w_grant_id == REQ_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

`ifdef CPU_REG_ARB_ADDR_CHECK_EN
    localparam logic [REG_SEL_W-1:0] LAST_ADDR = REG_SEL_W'(NUM_REGS - 1);
    assign w_addr_ok  = (r_addr <= LAST_ADDR);
    assign w_resp_err = !w_addr_ok;
`else
    assign w_addr_ok  = 1'b1;
    assign w_resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_id    <= REQ_CPU;
        end else begin
            r_state <= w_next;
            if (w_idle && w_grant_vld) begin
                r_id <= w_grant_id;
            end
        end
    end

    // Access fields are only consumed after a grant, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_idle && w_grant_vld) begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else if ((r_state == RD) && w_addr_ok) begin
            if (r_id == REQ_DBG) begin
                r_dbg_rdata <= bus.rf_data_out;
            end else begin
                r_cpu_rdata <= bus.rf_data_out;
            end
        end
    end

    // Strobes and acks decode from registered state only: no req-to-rf path.
    always_comb begin
        w_next               = r_state;
        bus.rf_enable_write  = 1'b0;
        bus.rf_output_enable = 1'b0;
        bus.rf_sel_in        = '0;
        bus.rf_sel_out       = '0;
        bus.rf_data_in       = '0;
        bus.cpu_ack          = 1'b0;
        bus.dbg_ack          = 1'b0;
        bus.cpu_err          = 1'b0;
        bus.dbg_err          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_next = w_sel_we ? WR : RD;
                end
            end
            WR: begin
                w_next = RESP;
                if (w_addr_ok) begin
                    bus.rf_enable_write = 1'b1;
                    bus.rf_sel_in       = r_addr;
                    bus.rf_data_in      = r_wdata;
                end
            end
            RD: begin
                w_next = RESP;
                if (w_addr_ok) begin
                    bus.rf_output_enable = 1'b1;
                    bus.rf_sel_out       = r_addr;
                end
            end
            RESP: begin
                w_next = IDLE;
                if (r_id == REQ_DBG) begin
                    bus.dbg_ack = 1'b1;
                    bus.dbg_err = w_resp_err;
                end else begin
                    bus.cpu_ack = 1'b1;
                    bus.cpu_err = w_resp_err;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.busy      = !w_idle;

endmodule
